// File: rtl/dcache_controller.sv
// Write-back, write-allocate L1 data-cache controller in front of a 2-way set-associative tag/data SRAM.
// Hits complete combinationally; misses stall the CPU through writeback / refill / fill.
module dcache_controller #(
  parameter int LINE_BITS   = 256,
  parameter int SETS_LOG2   = 4,
  parameter int OFFSET_BITS = 5
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [31:0]                        cpu_addr_i,
  input  logic [31:0]                        cpu_data_i,
  input  logic                               cpu_MemRead_i,
  input  logic                               cpu_MemWrite_i,
  output logic [31:0]                        cpu_data_o,
  output logic                               cpu_stall_o,
  output logic [31:0]                        mem_addr_o,
  output logic [LINE_BITS-1:0]               mem_data_o,
  output logic                               mem_enable_o,
  output logic                               mem_write_o,
  input  logic [LINE_BITS-1:0]               mem_data_i,
  input  logic                               mem_ack_i,
  output logic [SETS_LOG2-1:0]               sram_addr_o,
  output logic [31-SETS_LOG2-OFFSET_BITS+2:0] sram_tag_o,
  output logic [LINE_BITS-1:0]               sram_data_o,
  output logic                               sram_enable_o,
  output logic                               sram_write_o,
  input  logic [31-SETS_LOG2-OFFSET_BITS+2:0] sram_tag_i,
  input  logic [LINE_BITS-1:0]               sram_data_i,
  input  logic                               sram_hit_i
);

  localparam int TAG_BITS = 32 - SETS_LOG2 - OFFSET_BITS;
  localparam int WORD_SEL = OFFSET_BITS - 2;
  localparam int WORDS    = LINE_BITS / 32;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FILL} state_t;

  state_t                 state_reg, state_next;
  logic [TAG_BITS-1:0]    victim_tag_reg;
  logic [LINE_BITS-1:0]   victim_line_reg;
  logic [LINE_BITS-1:0]   fill_buf_reg;

  logic [TAG_BITS-1:0]    tag;
  logic [SETS_LOG2-1:0]   index;
  logic [WORD_SEL-1:0]    word;
  logic                   req, is_store, is_load, hit, miss, victim_dirty;
  logic [31:0]            load_word;
  logic [LINE_BITS-1:0]   merged_line;

  assign tag          = cpu_addr_i[31 -: TAG_BITS];
  assign index        = cpu_addr_i[OFFSET_BITS +: SETS_LOG2];
  assign word         = cpu_addr_i[OFFSET_BITS-1:2];
  assign sram_addr_o  = index;

  // A simultaneous read+write request is a store.
  assign req          = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_store     = cpu_MemWrite_i;
  assign is_load      = cpu_MemRead_i & ~cpu_MemWrite_i;
  // The SRAM compares raw tags; an invalid entry must never count as a hit.
  assign hit          = sram_hit_i & sram_tag_i[TAG_BITS+1];
  assign miss         = req & ~hit;
  assign victim_dirty = (sram_tag_i[TAG_BITS+1:TAG_BITS] == 2'b11);

  assign load_word    = sram_data_i[{word, 5'd0} +: 32];

  // Store-hit line: the resident line with only the addressed word replaced.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_merge
      assign merged_line[gi*32 +: 32] = (word == WORD_SEL'(gi)) ? cpu_data_i
                                                                : sram_data_i[gi*32 +: 32];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      victim_tag_reg  <= '0;
      victim_line_reg <= '0;
      fill_buf_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && miss && victim_dirty) begin
        victim_tag_reg  <= sram_tag_i[TAG_BITS-1:0];
        victim_line_reg <= sram_data_i;
      end
      if (state_reg == REFILL && mem_ack_i) begin
        fill_buf_reg <= mem_data_i;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    cpu_stall_o   = 1'b1;
    cpu_data_o    = '0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    sram_tag_o    = {2'b00, tag};
    sram_data_o   = '0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;

    case (state_reg)
      IDLE: begin
        cpu_stall_o = miss;
        if (req && hit) begin
          sram_enable_o = 1'b1;
          if (is_store) begin
            sram_write_o = 1'b1;
            sram_tag_o   = {2'b11, tag};
            sram_data_o  = merged_line;
          end else if (is_load) begin
            cpu_data_o = load_word;
          end
        end else if (miss) begin
          // SRAM stays disabled here so the miss does not disturb LRU.
          state_next = victim_dirty ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {victim_tag_reg, index, {OFFSET_BITS{1'b0}}};
        mem_data_o   = victim_line_reg;
        if (mem_ack_i) state_next = REFILL;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, index, {OFFSET_BITS{1'b0}}};
        if (mem_ack_i) state_next = FILL;
      end
      FILL: begin
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        sram_tag_o    = {2'b10, tag};
        sram_data_o   = fill_buf_reg;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (rst_i) begin
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: 2-way LRU SRAM and latency-programmable memory around the DUT,
// an architectural word-memory model plus expected-memory-operation queue checked every cycle.
module tb_dcache_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]  cpu_addr, cpu_wdata, cpu_data_o;
  logic         cpu_rd, cpu_wr, cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i, sram_data_o, sram_data_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic         sram_enable_o, sram_write_o, sram_hit_i;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_MemRead_i(cpu_rd), .cpu_MemWrite_i(cpu_wr),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- SRAM model: 16 sets x 2 ways, one LRU bit per set ----------------
  logic [24:0]  tag_mem  [16][2];
  logic [255:0] data_mem [16][2];
  logic         lru      [16];
  logic         sram_clr;

  function automatic logic sel_way(input logic [3:0] idx, input logic [22:0] t);
    logic w = lru[idx];
    for (int k = 0; k < 2; k++)
      if (tag_mem[idx][k][24] && tag_mem[idx][k][22:0] == t) w = k[0];
    return w;
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    logic h = 1'b0;
    for (int k = 0; k < 2; k++)
      if (tag_mem[a[8:5]][k][24] && tag_mem[a[8:5]][k][22:0] == a[31:9]) h = 1'b1;
    return h;
  endfunction

  // Lookup returns the valid matching way, else the LRU victim; an invalid victim whose
  // stale tag happens to match still raises the raw hit line.
  always_comb begin
    logic w;
    w           = sel_way(cpu_addr[8:5], cpu_addr[31:9]);
    sram_tag_i  = tag_mem[cpu_addr[8:5]][w];
    sram_data_i = data_mem[cpu_addr[8:5]][w];
    sram_hit_i  = (sram_tag_i[22:0] == cpu_addr[31:9]);
  end

  always @(posedge clk) begin
    if (sram_clr) begin
      for (int s = 0; s < 16; s++) begin
        lru[s] <= 1'b0;
        for (int k = 0; k < 2; k++) begin
          tag_mem[s][k]  <= '0;
          data_mem[s][k] <= '0;
        end
      end
    end else if (sram_enable_o) begin
      if (sram_write_o) begin
        tag_mem[sram_addr_o][sel_way(sram_addr_o, sram_tag_o[22:0])]  <= sram_tag_o;
        data_mem[sram_addr_o][sel_way(sram_addr_o, sram_tag_o[22:0])] <= sram_data_o;
      end
      lru[sram_addr_o] <= ~sel_way(sram_addr_o, sram_tag_o[22:0]);
    end
  end

  // ---------------- backing memory and architectural model ----------------
  logic [255:0] backing [logic [31:0]];
  logic [31:0]  golden  [logic [31:0]];

  function automatic logic [255:0] backing_line(input logic [31:0] a);
    logic [255:0] l;
    if (backing.exists(a)) return backing[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (a + 32'(w*4)) ^ 32'hC0DE0000;
    return l;
  endfunction

  function automatic logic [31:0] golden_word(input logic [31:0] a);
    logic [255:0] l;
    if (golden.exists({a[31:2], 2'b00})) return golden[{a[31:2], 2'b00}];
    l = backing_line({a[31:5], 5'b0});
    return l[a[4:2]*32 +: 32];
  endfunction

  int   mem_delay = 5;
  int   mem_cnt   = 0;
  logic inject    = 1'b0;

  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack_i = 1'b0;
      if (inject) begin
        mem_ack_i = 1'b1;
        inject    = 1'b0;
      end else if (mem_enable_o) begin
        mem_cnt++;
        if (mem_cnt >= mem_delay) begin
          mem_ack_i = 1'b1;
          mem_cnt   = 0;
          if (mem_write_o) backing[mem_addr_o] = mem_data_o;
          else             mem_data_i = backing_line(mem_addr_o);
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // ---------------- expected memory operations and per-cycle compare ----------------
  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_op_t;

  mem_op_t exp_q[$];
  logic    fill_pending = 1'b0;
  logic    run_checks   = 1'b0;

  task automatic plan_miss(input logic [31:0] a);
    mem_op_t op;
    logic    w;
    w = lru[a[8:5]];
    if (tag_mem[a[8:5]][w][24:23] == 2'b11) begin
      op.wr   = 1'b1;
      op.addr = {tag_mem[a[8:5]][w][22:0], a[8:5], 5'b0};
      op.data = data_mem[a[8:5]][w];
      exp_q.push_back(op);
    end
    op.wr   = 1'b0;
    op.addr = {a[31:5], 5'b0};
    op.data = '0;
    exp_q.push_back(op);
  endtask

  initial begin : cmp
    logic         req, mh;
    logic [255:0] line;
    mem_op_t      op;
    forever begin
      @(negedge clk);
      if (!rst && run_checks) begin
        req = cpu_rd | cpu_wr;
        mh  = model_hit(cpu_addr);
        chk("sram_addr", 256'(sram_addr_o), 256'(cpu_addr[8:5]));
        chk("sram_tag_lo", 256'(sram_tag_o[22:0]), 256'(cpu_addr[31:9]));
        chk("stall", 256'(cpu_stall_o), 256'(req && !mh));
        if (req && mh && cpu_rd && !cpu_wr)
          chk("load_data", 256'(cpu_data_o), 256'(golden_word(cpu_addr)));
        else
          chk("data_zero", 256'(cpu_data_o), 256'(0));
        if (!req) begin
          chk("idle_maddr", 256'(mem_addr_o), 256'(0));
          chk("idle_mdata", mem_data_o, 256'(0));
        end
        if (req && mh) begin
          chk("hit_en", 256'(sram_enable_o), 256'(1));
          chk("hit_we", 256'(sram_write_o), 256'(cpu_wr));
          chk("hit_mem_en", 256'(mem_enable_o), 256'(0));
          chk("hit_maddr", 256'(mem_addr_o), 256'(0));
          if (cpu_wr) begin
            for (int k = 0; k < 2; k++)
              if (tag_mem[cpu_addr[8:5]][k][24] && tag_mem[cpu_addr[8:5]][k][22:0] == cpu_addr[31:9])
                line = data_mem[cpu_addr[8:5]][k];
            line[cpu_addr[4:2]*32 +: 32] = cpu_wdata;
            chk("st_tag", 256'(sram_tag_o), 256'({2'b11, cpu_addr[31:9]}));
            chk("st_line", sram_data_o, line);
            golden[{cpu_addr[31:2], 2'b00}] = cpu_wdata;
          end
        end else begin
          chk("fill_en", 256'(sram_enable_o), 256'(fill_pending));
          chk("fill_we", 256'(sram_write_o), 256'(fill_pending));
          if (fill_pending) begin
            chk("fill_tag", 256'(sram_tag_o), 256'({2'b10, cpu_addr[31:9]}));
            chk("fill_line", sram_data_o, backing_line({cpu_addr[31:5], 5'b0}));
            fill_pending = 1'b0;
          end
          if (exp_q.size() == 0) begin
            chk("mem_quiet", 256'(mem_enable_o), 256'(0));
          end else if (mem_enable_o) begin
            op = exp_q[0];
            chk("mem_we", 256'(mem_write_o), 256'(op.wr));
            chk("mem_addr", 256'(mem_addr_o), 256'(op.addr));
            if (op.wr) chk("wb_line", mem_data_o, op.data);
            if (mem_ack_i) begin
              void'(exp_q.pop_front());
              if (!op.wr) fill_pending = 1'b1;
            end
          end
        end
      end
    end
  end

  // Last-seen memory/SRAM traffic, used to pin the model with literal expectations.
  logic [31:0]  last_rf_addr, last_wb_addr;
  logic [255:0] last_wb_data;
  logic [24:0]  last_fill_tag;
  initial forever begin
    @(negedge clk);
    if (mem_enable_o && mem_write_o) begin
      last_wb_addr = mem_addr_o;
      last_wb_data = mem_data_o;
    end
    if (mem_enable_o && !mem_write_o) last_rf_addr = mem_addr_o;
    if (sram_write_o && cpu_stall_o) last_fill_tag = sram_tag_o;
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic wr, input int exp_stall,
                        output logic [31:0] rdata);
    int n;
    @(posedge clk);
    #1;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_rd    = rd;
    cpu_wr    = wr;
    if (!model_hit(a)) plan_miss(a);
    n = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall_o) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout stall still high after %0d cycles", nm, n);
        break;
      end
    end
    chk({nm, "_stalls"}, 256'(n), 256'(exp_stall));
    rdata = cpu_data_o;
    $display("txn %s addr=%08h rd=%0b wr=%0b wdata=%08h rdata=%08h stalls=%0d",
             nm, a, rd, wr, d, rdata, n);
  endtask

  logic [31:0]  rdata;
  logic [255:0] l40;

  initial begin
    rst       = 1'b1;
    sram_clr  = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    for (int w = 0; w < 8; w++) l40[w*32 +: 32] = 32'h10 + 32'(w);
    backing[32'h40] = l40;

    repeat (2) @(posedge clk);
    #1;
    sram_clr = 1'b0;
    chk("rst_mem_en", 256'(mem_enable_o), 256'(0));
    chk("rst_mem_we", 256'(mem_write_o), 256'(0));
    chk("rst_sram_en", 256'(sram_enable_o), 256'(0));
    chk("rst_sram_we", 256'(sram_write_o), 256'(0));
    chk("rst_stall", 256'(cpu_stall_o), 256'(0));
    chk("rst_maddr", 256'(mem_addr_o), 256'(0));
    @(negedge clk);
    rst        = 1'b0;
    run_checks = 1'b1;

    // Cold load: invalid tag-0 entry must miss; refill 5 cycles + 2.
    do_req("cold_ld", 32'h0000_0044, 32'h0, 1'b1, 1'b0, 7, rdata);
    chk("cold_word", 256'(rdata), 256'(32'h11));
    chk("cold_rf_addr", 256'(last_rf_addr), 256'(32'h40));
    chk("cold_fill_tag", 256'(last_fill_tag), 256'(25'h100_0000));

    do_req("st_hit", 32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, rdata);
    chk("st_tag_lit", 256'(sram_tag_o), 256'(25'h180_0000));
    chk("st_word1_lit", 256'(sram_data_o[63:32]), 256'(32'hDEAD_BEEF));
    chk("st_we_lit", 256'(sram_write_o), 256'(1));
    do_req("ld_back", 32'h0000_0044, 32'h0, 1'b1, 1'b0, 0, rdata);
    chk("ld_back_lit", 256'(rdata), 256'(32'hDEAD_BEEF));

    // Second way of set 2, then dirty it with read+write both high.
    do_req("ld_t1", 32'h0000_0240, 32'h0, 1'b1, 1'b0, 7, rdata);
    do_req("both_hi", 32'h0000_0248, 32'hA5A5_A5A5, 1'b1, 1'b1, 0, rdata);
    chk("both_tag_lit", 256'(sram_tag_o), 256'(25'h180_0001));
    chk("both_we_lit", 256'(sram_write_o), 256'(1));
    chk("both_data_lit", 256'(cpu_data_o), 256'(0));

    // Dirty victim (tag 0, LRU) written back, then refill of tag 2.
    mem_delay = 3;
    do_req("ld_t2_wb", 32'h0000_0448, 32'h0, 1'b1, 1'b0, 8, rdata);
    chk("wb_addr_lit", 256'(last_wb_addr), 256'(32'h40));
    chk("wb_word1_lit", 256'(last_wb_data[63:32]), 256'(32'hDEAD_BEEF));
    chk("t2_word_lit", 256'(rdata), 256'(32'hC0DE_0448));
    do_req("reload_0", 32'h0000_0044, 32'h0, 1'b1, 1'b0, 8, rdata);
    chk("reload_lit", 256'(rdata), 256'(32'hDEAD_BEEF));
    chk("wb2_addr_lit", 256'(last_wb_addr), 256'(32'h240));
    chk("wb2_word2_lit", 256'(last_wb_data[95:64]), 256'(32'hA5A5_A5A5));

    // Long refill: outputs held for 20 cycles.
    mem_delay = 20;
    do_req("slow_ld", 32'h1000_0084, 32'h0, 1'b1, 1'b0, 22, rdata);
    chk("slow_lit", 256'(rdata), 256'(32'hD0DE_0084));

    // Reset during REFILL cycle 3, then a stray ack, then retry.
    mem_delay = 5;
    @(posedge clk);
    #1;
    cpu_addr = 32'h2000_00C4;
    cpu_rd   = 1'b1;
    cpu_wr   = 1'b0;
    plan_miss(cpu_addr);
    repeat (3) @(posedge clk);
    #3;
    rst    = 1'b1;
    cpu_rd = 1'b0;
    #1;
    chk("mrst_mem_en", 256'(mem_enable_o), 256'(0));
    chk("mrst_mem_we", 256'(mem_write_o), 256'(0));
    chk("mrst_sram_en", 256'(sram_enable_o), 256'(0));
    chk("mrst_sram_we", 256'(sram_write_o), 256'(0));
    chk("mrst_maddr", 256'(mem_addr_o), 256'(0));
    exp_q.delete();
    fill_pending = 1'b0;
    $display("txn reset_in_refill addr=%08h", cpu_addr);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    inject = 1'b1;
    repeat (3) @(negedge clk);
    chk("late_ack_no_fill", 256'(model_hit(32'h2000_00C4)), 256'(0));
    do_req("retry_ld", 32'h2000_00C4, 32'h0, 1'b1, 1'b0, 7, rdata);
    chk("retry_lit", 256'(rdata), 256'(32'hE0DE_00C4));

    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_q_empty", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Write-back, write-allocate L1 data-cache controller that sits directly upstream of dcache_sram (2-way, 16 sets, 256-bit lines, 25-bit tag entries).
- Decodes CPU word requests and detects hits.
- On a miss, stalls the CPU and runs an optional dirty-victim writeback, then a line refill from data memory.
- Returns the requested 32-bit word to the CPU.

Parameters:
- LINE_BITS, 256, cache line width
- SETS_LOG2, 4, index width (16 sets)
- OFFSET_BITS, 5, byte offset within a line

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  request not yet complete
- mem_addr_o  out  32  line-aligned memory address
- mem_data_o  out  256  writeback line
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1=write, 0=read
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_enable_o  out  1  SRAM access (updates LRU)
- sram_write_o  out  1  SRAM write
- sram_tag_i  in  25  tag entry of hit way, or LRU victim on miss
- sram_data_i  in  256  line of hit way, or LRU victim
- sram_hit_i  in  1  tag match from SRAM

Behaviour:
- Address split:
  - tag = addr[31:9]
  - index = addr[8:5]
  - word = addr[4:2]
  - sram_addr_o = index always
  - sram_tag_o low 23 bits = tag
- req = MemRead | MemWrite. If both are asserted, the request is treated as a write.
- hit = sram_hit_i & sram_tag_i[24]. Tag 0 with valid=0 is never a hit.
- The CPU holds addr, data and request stable while cpu_stall_o=1.
- cpu_stall_o = req & ~hit (combinational). It is also forced to 1 in any state other than IDLE.
- Load hit:
  - cpu_data_o = sram_data_i[word*32 +: 32] in the same cycle, zero latency.
  - cpu_data_o = 0 when there is no load hit.
- Hit in IDLE asserts sram_enable_o so the SRAM updates LRU.
- Store hit, same cycle:
  - sram_enable_o = sram_write_o = 1.
  - sram_data_o = sram_data_i with the selected word replaced by cpu_data_i.
  - sram_tag_o = {1,1,tag}.
- No SRAM enable on a miss in IDLE. This prevents a spurious LRU flip.
- FSM states: IDLE, WRITEBACK, REFILL, FILL.
  - IDLE -> WRITEBACK on req & ~hit & victim valid & dirty (sram_tag_i[24:23]==2'b11). Latch victim tag and line on this transition.
  - IDLE -> REFILL on req & ~hit with a clean or invalid victim.
  - WRITEBACK:
    - mem_enable_o=1, mem_write_o=1.
    - mem_addr_o = {victim_tag, index, 5'b0}.
    - mem_data_o = latched victim line.
    - Outputs held stable until mem_ack_i; on ack -> REFILL.
  - REFILL:
    - mem_enable_o=1, mem_write_o=0.
    - mem_addr_o = {tag, index, 5'b0}.
    - Held stable until mem_ack_i; on ack, latch mem_data_i into the fill buffer -> FILL.
  - FILL, one cycle:
    - sram_enable_o = sram_write_o = 1.
    - sram_tag_o = {1,0,tag}, sram_data_o = fill buffer.
    - The SRAM places the line in the LRU way.
    - -> IDLE.
- After a miss, the request hits in IDLE and completes as a normal hit. A store therefore sets dirty on that cycle.
- Miss latency = writeback memory latency (if dirty) + refill memory latency + 2 cycles.
- mem_ack_i is ignored in IDLE and FILL.
- mem_enable_o is 0 in IDLE and FILL; mem_data_o and mem_addr_o are 0 in IDLE.
- Reset, at any time including mid-transaction:
  - FSM -> IDLE; buffers cleared.
  - mem_enable_o, mem_write_o, sram_enable_o, sram_write_o = 0.
  - The pending memory transaction is abandoned and a late ack is ignored.

Test Plan:
- Cold load 0x0000_0044 with a memory line of words 0..7 = 0x10..0x17 and ack after 5 cycles:
  - REFILL on mem_addr 0x40, then FILL writes tag {1,0,0}.
  - Stall deasserts the cycle after FILL; cpu_data_o = 0x11.
- Store 0xDEADBEEF to 0x44 after the line is resident:
  - No stall; SRAM write same cycle with tag {1,1,0} and word1 = 0xDEADBEEF.
- Fill both ways of set 2 dirty, then load an address with a new tag in set 2:
  - WRITEBACK of the LRU victim at {victim_tag,2,0} with the victim line on mem_data_o.
  - Then REFILL, then the new data returns.
- Refill ack delayed 20 cycles:
  - mem_addr_o and mem_enable_o stable for all 20 cycles.
  - cpu_stall_o=1 throughout.
- Assert rst_i in REFILL cycle 3:
  - Outputs immediately idle.
  - A later ack causes no SRAM write.
  - The retried request misses again.
- MemRead and MemWrite both high on a hit:
  - Store performed; dirty set.
